// File: rtl/regfile_sb.sv
// Register file with posedge writeback, write-to-read bypass on all read ports,
// a per-register busy scoreboard and a wrapping committed-write counter.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] debug_addr,
  output logic [DATA_W-1:0] debug_data,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              wr_commit;
  logic              issue_ok;

  // Register 0 is never written or marked busy, so it reads as zero without a special read path.
  assign wr_commit = we && !((ZERO_REG != 0) && (waddr == '0));
  assign issue_ok  = issue_valid && !((ZERO_REG != 0) && (issue_addr == '0));

  assign rdata_a    = (wr_commit && (waddr == raddr_a))    ? wdata : regs_q[raddr_a];
  assign rdata_b    = (wr_commit && (waddr == raddr_b))    ? wdata : regs_q[raddr_b];
  assign debug_data = (wr_commit && (waddr == debug_addr)) ? wdata : regs_q[debug_addr];

  assign busy_a = busy_q[raddr_a] && !(wr_commit && (waddr == raddr_a));
  assign busy_b = busy_q[raddr_b] && !(wr_commit && (waddr == raddr_b));

  assign wr_count = cnt_q;

  // Issue is applied after the writeback clear so a same-address issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_commit) busy_d[waddr] = 1'b0;
      if (issue_ok)  busy_d[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      if (wr_commit) begin
        regs_q[waddr] <= wdata;
        cnt_q         <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
